// File: rtl/regfile_writeback_pkg.sv
// Shared types and default widths for the register-file writeback front end.
// Optional feature macro: REGFILE_WB_TRACE_EN (retirement trace, source bit per entry).
package regfile_wb_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 64;
  localparam int unsigned RF_DEPTH  = 4;
  localparam int unsigned RF_PEND_W = 3;

  // One writeback request at the default widths.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

  // Which unit produced a writeback.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_writeback_if.sv
// Bus bundle for regfile_writeback: ALU/LSU writeback handshakes, issue port,
// hazard queries, stall and the register-file write port.
//   master : producer side (core / testbench) - drives requests and queries
//   slave  : regfile_writeback - drives readies, busy flags and rf_*
interface regfile_writeback_if #(
  parameter int unsigned ADDR_WIDTH = regfile_wb_pkg::RF_ADDR_W,
  parameter int unsigned DATA_WIDTH = regfile_wb_pkg::RF_DATA_W
);

  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;

  logic                  issue_valid;
  logic                  issue_ready;
  logic [ADDR_WIDTH-1:0] issue_rd;

  logic [ADDR_WIDTH-1:0] q_rs1;
  logic [ADDR_WIDTH-1:0] q_rs2;
  logic                  q_rs1_busy;
  logic                  q_rs2_busy;

  logic                  stall;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_rd;
  logic [DATA_WIDTH-1:0] rf_dataD;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_valid, issue_rd,
    output q_rs1, q_rs2, stall,
    input  alu_ready, lsu_ready, issue_ready,
    input  q_rs1_busy, q_rs2_busy,
    input  rf_wen, rf_rd, rf_dataD
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_valid, issue_rd,
    input  q_rs1, q_rs2, stall,
    output alu_ready, lsu_ready, issue_ready,
    output q_rs1_busy, q_rs2_busy,
    output rf_wen, rf_rd, rf_dataD
  );

endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head is visible combinationally.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push, din  : enqueue din (ignored when full unless popping the same cycle)
//   pop        : retire head (ignored when empty)
//   head       : current head entry
//   full/empty : occupancy flags
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  T            r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  // Same index with differing wrap bit means the writer lapped the reader.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign head  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage needs no reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-side front end: arbitrates ALU/LSU writebacks (LSU first),
// buffers them in wb_fifo, drains one per cycle onto the register-file write
// port, and keeps per-register pending counters for RAW hazard queries.
// Ports:
//   clk, rst_n : clock, async active-low reset (flushes queue and scoreboard)
//   bus        : regfile_writeback_if.slave - ALU/LSU handshakes, issue port,
//                q_rs1/q_rs2 busy queries, stall, rf_wen/rf_rd/rf_dataD
// Optional: define REGFILE_WB_TRACE_EN to print each retirement with its source.
module regfile_writeback #(
  parameter int unsigned ADDR_WIDTH = regfile_wb_pkg::RF_ADDR_W,
  parameter int unsigned DATA_WIDTH = regfile_wb_pkg::RF_DATA_W,
  parameter int unsigned DEPTH      = regfile_wb_pkg::RF_DEPTH,
  parameter int unsigned PEND_W     = regfile_wb_pkg::RF_PEND_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_writeback_if.slave   bus
);

  import regfile_wb_pkg::*;

  localparam int unsigned       NREGS    = 1 << ADDR_WIDTH;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
`ifdef REGFILE_WB_TRACE_EN
    wb_src_e               src;
`endif
  } entry_t;

  entry_t                w_push_entry;
  entry_t                w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_space;
  logic                  w_lsu_fire;
  logic                  w_alu_fire;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue_fire;
  logic [NREGS-1:0]      w_inc_vec;
  logic [NREGS-1:0]      w_dec_vec;
  logic [PEND_W-1:0]     r_pend [NREGS];
  logic [ADDR_WIDTH-1:0] r_last_rd;
  logic [DATA_WIDTH-1:0] r_last_data;

  // Room for an enqueue: a free slot, or a full queue that is draining now.
  // Readies are also held low while reset is asserted.
  assign w_space = rst_n && (!w_full || (!bus.stall && !w_empty));

  assign bus.lsu_ready = w_space;
  assign bus.alu_ready = w_space && !bus.lsu_valid;

  assign w_lsu_fire = bus.lsu_valid && bus.lsu_ready;
  assign w_alu_fire = bus.alu_valid && bus.alu_ready;

  // x0 writes complete the handshake but are dropped here.
  assign w_push = (w_lsu_fire && (bus.lsu_rd != '0)) ||
                  (w_alu_fire && (bus.alu_rd != '0));

  // Winning request becomes the FIFO entry.
  always_comb begin
    w_push_entry      = '0;
    w_push_entry.rd   = w_lsu_fire ? bus.lsu_rd   : bus.alu_rd;
    w_push_entry.data = w_lsu_fire ? bus.lsu_data : bus.alu_data;
`ifdef REGFILE_WB_TRACE_EN
    w_push_entry.src  = w_lsu_fire ? WB_SRC_LSU : WB_SRC_ALU;
`endif
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_push_entry),
    .pop   (w_pop),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Drain: head is written to the register file on the edge where rf_wen=1.
  assign w_pop        = !w_empty && !bus.stall;
  assign bus.rf_wen   = w_pop;
  assign bus.rf_rd    = w_empty ? r_last_rd   : w_head.rd;
  assign bus.rf_dataD = w_empty ? r_last_data : w_head.data;

  // Last retired value, shown on rf_* while the queue is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_rd   <= '0;
      r_last_data <= '0;
    end else if (w_pop) begin
      r_last_rd   <= w_head.rd;
      r_last_data <= w_head.data;
    end
  end

  // A saturated counter may still accept an issue when it is decremented this cycle.
  assign bus.issue_ready = (r_pend[bus.issue_rd] != PEND_MAX) ||
                           (w_pop && (w_head.rd == bus.issue_rd));
  assign w_issue_fire    = bus.issue_valid && bus.issue_ready && (bus.issue_rd != '0);

  // One-hot increment/decrement selects; x0 never tracked.
  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    if (w_issue_fire) w_inc_vec[bus.issue_rd] = 1'b1;
    if (w_pop)        w_dec_vec[w_head.rd]    = 1'b1;
    w_inc_vec[0] = 1'b0;
    w_dec_vec[0] = 1'b0;
  end

  // Pending counters; a decrement at zero holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) r_pend[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (w_inc_vec[i] && !w_dec_vec[i]) begin
          r_pend[i] <= r_pend[i] + 1'b1;
        end else if (w_dec_vec[i] && !w_inc_vec[i] && (r_pend[i] != '0)) begin
          r_pend[i] <= r_pend[i] - 1'b1;
        end
      end
    end
  end

  // Hazard queries see committed counters only; no same-cycle forwarding.
  assign bus.q_rs1_busy = (bus.q_rs1 != '0) && (r_pend[bus.q_rs1] != '0);
  assign bus.q_rs2_busy = (bus.q_rs2 != '0) && (r_pend[bus.q_rs2] != '0);

`ifndef SYNTHESIS
  // Retiring a register that decode never marked pending is a protocol error.
  always @(posedge clk) begin
    if (rst_n && w_pop && (r_pend[w_head.rd] == '0)) begin
      $error("regfile_writeback: retirement of x%0d with no pending write", w_head.rd);
    end
  end
`endif

`ifdef REGFILE_WB_TRACE_EN
  // Retirement trace.
  always @(posedge clk) begin
    if (rst_n && w_pop) begin
      $display("wb x%0d <= 0x%0x (%0d) src=%s", w_head.rd, w_head.data,
               $signed(w_head.data), (w_head.src == WB_SRC_LSU) ? "LSU" : "ALU");
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios followed by a
// randomized run checked against a queue/array reference model.
module tb_regfile_writeback;
  import regfile_wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  regfile_writeback_if #(.ADDR_WIDTH(RF_ADDR_W), .DATA_WIDTH(RF_DATA_W)) bus ();

  regfile_writeback #(
    .ADDR_WIDTH (RF_ADDR_W),
    .DATA_WIDTH (RF_DATA_W),
    .DEPTH      (4),
    .PEND_W     (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [63:0] d);
    bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic lsu(input logic v, input logic [4:0] rd, input logic [63:0] d);
    bus.lsu_valid = v; bus.lsu_rd = rd; bus.lsu_data = d;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd);
    bus.issue_valid = v; bus.issue_rd = rd;
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state for the randomized phase.
  wb_req_t     mq[$];
  logic [4:0]  outst[$];
  int          pend[32];
  logic [4:0]  last_rd;
  logic [63:0] last_data;

  initial begin
    int          li, ai, n;
    logic        req_en, e_wen, e_space, e_irdy, lsu_fire, alu_fire;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
    wb_req_t     t;

    rst_n = 1'b1;
    alu(0, 0, 0); lsu(0, 0, 0); issue(0, 0);
    bus.stall = 1'b0; bus.q_rs1 = '0; bus.q_rs2 = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_alu_ready", bus.alu_ready, 0);
    chk("rst_lsu_ready", bus.lsu_ready, 0);
    chk("rst_rf_wen",    bus.rf_wen,    0);
    chk("rst_rf_rd",     bus.rf_rd,     0);
    chk("rst_rf_dataD",  bus.rf_dataD,  0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rel_issue_ready", bus.issue_ready, 1);
    chk("rel_lsu_ready",   bus.lsu_ready,   1);
    chk("rel_alu_ready",   bus.alu_ready,   1);

    // Single ALU write, one-cycle latency, visible for one cycle only.
    issue(1, 5); tick(); issue(0, 0);
    bus.q_rs1 = 5; alu(1, 5, 64'h1234); #1;
    chk("a_busy_pre",  bus.q_rs1_busy, 1);
    chk("a_alu_ready", bus.alu_ready,  1);
    chk("a_wen_pre",   bus.rf_wen,     0);
    tick(); alu(0, 0, 0); #1;
    chk("a_wen",      bus.rf_wen,     1);
    chk("a_rd",       bus.rf_rd,      5);
    chk("a_data",     bus.rf_dataD,   64'h1234);
    chk("a_busy_ret", bus.q_rs1_busy, 1);
    tick();
    chk("a_wen_after", bus.rf_wen,     0);
    chk("a_rd_hold",   bus.rf_rd,      5);
    chk("a_busy_after", bus.q_rs1_busy, 0);

    // LSU beats ALU; ALU holds and goes next.
    issue(1, 3); tick(); issue(1, 4); tick(); issue(0, 0);
    lsu(1, 3, 64'h33); alu(1, 4, 64'h44); #1;
    chk("b_lsu_ready", bus.lsu_ready, 1);
    chk("b_alu_ready", bus.alu_ready, 0);
    tick(); lsu(0, 0, 0); #1;
    chk("b_alu_ready2", bus.alu_ready, 1);
    chk("b_wen1",  bus.rf_wen,   1);
    chk("b_rd1",   bus.rf_rd,    3);
    chk("b_data1", bus.rf_dataD, 64'h33);
    tick(); alu(0, 0, 0); #1;
    chk("b_wen2",  bus.rf_wen,   1);
    chk("b_rd2",   bus.rf_rd,    4);
    chk("b_data2", bus.rf_dataD, 64'h44);
    tick();
    chk("b_wen3", bus.rf_wen, 0);

    // Stall: fill to depth, ready drops, then drain in order.
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin issue(1, 5'(8 + i)); tick(); end
    issue(0, 0);
    for (int i = 0; i < 4; i++) begin
      alu(1, 5'(8 + i), 64'(128 + i)); #1;
      chk("c_alu_ready", bus.alu_ready, 1);
      chk("c_wen_stall", bus.rf_wen,    0);
      tick();
    end
    alu(1, 12, 64'hdead); #1;
    chk("c_alu_ready_full", bus.alu_ready, 0);
    chk("c_lsu_ready_full", bus.lsu_ready, 0);
    alu(0, 0, 0); bus.stall = 1'b0; #1;
    chk("c_wen0",       bus.rf_wen,    1);
    chk("c_rd0",        bus.rf_rd,     8);
    chk("c_alu_ready_drain", bus.alu_ready, 1);
    chk("c_lsu_ready_drain", bus.lsu_ready, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("c_wen",  bus.rf_wen,   1);
      chk("c_rd",   bus.rf_rd,    5'(8 + i));
      chk("c_data", bus.rf_dataD, 64'(128 + i));
    end
    tick();
    chk("c_wen_end", bus.rf_wen, 0);

    // Busy tracking across two writes to x7; x0 query never busy.
    bus.q_rs1 = 7; bus.q_rs2 = 0;
    issue(1, 7); tick(); tick(); issue(0, 0);
    alu(1, 7, 64'h1); #1;
    chk("d_busy1_a", bus.q_rs1_busy, 1);
    chk("d_busy2_a", bus.q_rs2_busy, 0);
    tick(); alu(0, 0, 0); #1;
    chk("d_wen_a",   bus.rf_wen,     1);
    chk("d_busy1_b", bus.q_rs1_busy, 1);
    tick();
    chk("d_busy1_c", bus.q_rs1_busy, 1);
    alu(1, 7, 64'h2); tick(); alu(0, 0, 0); #1;
    chk("d_wen_b",   bus.rf_wen,     1);
    chk("d_busy1_d", bus.q_rs1_busy, 1);
    chk("d_busy2_d", bus.q_rs2_busy, 0);
    tick();
    chk("d_busy1_e", bus.q_rs1_busy, 0);
    chk("d_busy2_e", bus.q_rs2_busy, 0);

    // x0 request: accepted, never written.
    alu(1, 0, 64'hFFFF); #1;
    chk("e_alu_ready", bus.alu_ready, 1);
    tick(); alu(0, 0, 0); #1;
    chk("e_wen",  bus.rf_wen,   0);
    chk("e_rd",   bus.rf_rd,    7);
    chk("e_data", bus.rf_dataD, 64'h2);

    // Counter saturation, and issue accepted when decremented the same cycle.
    for (int i = 0; i < 7; i++) begin issue(1, 2); tick(); end
    #1;
    chk("s_ready_sat", bus.issue_ready, 0);
    tick(); issue(0, 2);
    alu(1, 2, 64'h22); tick(); alu(0, 0, 0);
    issue(1, 2); #1;
    chk("s_ready_dec", bus.issue_ready, 1);
    chk("s_wen",       bus.rf_wen,      1);
    tick(); issue(0, 2); #1;
    chk("s_ready_hold", bus.issue_ready, 0);

    // Async reset with three queued writes.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin issue(1, 5'(13 + i)); tick(); end
    issue(0, 0);
    for (int i = 0; i < 3; i++) begin alu(1, 5'(13 + i), 64'(240 + i)); tick(); end
    alu(0, 0, 0); bus.stall = 1'b0; bus.q_rs1 = 13; bus.q_rs2 = 15; #1;
    chk("f_wen_pre",  bus.rf_wen,     1);
    chk("f_rd_pre",   bus.rf_rd,      13);
    chk("f_busy_pre", bus.q_rs1_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("f_wen_rst",   bus.rf_wen,     0);
    chk("f_rd_rst",    bus.rf_rd,      0);
    chk("f_alu_rdy_rst", bus.alu_ready, 0);
    chk("f_busy1_rst", bus.q_rs1_busy, 0);
    chk("f_busy2_rst", bus.q_rs2_busy, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("f_wen_post",  bus.rf_wen,     0);
      chk("f_busy_post", bus.q_rs1_busy | bus.q_rs2_busy, 0);
      tick();
    end

    // Randomized phase against the reference model (state clean after reset).
    for (int r = 0; r < 32; r++) pend[r] = 0;
    last_rd = '0; last_data = '0;
    for (int c = 0; c < 400; c++) begin
      req_en    = (c % 80) >= 30;
      bus.stall = ($urandom_range(0, 5) == 0);
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
      bus.q_rs1 = 5'($urandom_range(0, 4));
      bus.q_rs2 = 5'($urandom_range(0, 4));
      li = -1; ai = -1;
      lsu(0, 0, 0); alu(0, 0, 0);
      if (req_en && $urandom_range(0, 2) == 0) begin
        lsu(1, 0, {$urandom, $urandom});
        if (outst.size() > 0 && $urandom_range(0, 7) != 0) begin
          li = int'($urandom_range(0, outst.size() - 1)); bus.lsu_rd = outst[li];
        end
      end
      if (req_en && $urandom_range(0, 1) == 0) begin
        alu(1, 0, {$urandom, $urandom});
        if (outst.size() > 0 && $urandom_range(0, 7) != 0) begin
          ai = int'($urandom_range(0, outst.size() - 1)); bus.alu_rd = outst[ai];
        end
      end
      #1;
      n       = mq.size();
      e_wen   = (n != 0) && !bus.stall;
      e_rd    = (n != 0) ? mq[0].rd   : last_rd;
      e_data  = (n != 0) ? mq[0].data : last_data;
      e_space = (n < 4) || (!bus.stall && n > 0);
      e_irdy  = (pend[bus.issue_rd] != 7) || (e_wen && (mq[0].rd == bus.issue_rd));
      chk($sformatf("rnd%0d_wen", c),   bus.rf_wen,    e_wen);
      chk($sformatf("rnd%0d_rd", c),    bus.rf_rd,     e_rd);
      chk($sformatf("rnd%0d_data", c),  bus.rf_dataD,  e_data);
      chk($sformatf("rnd%0d_lrdy", c),  bus.lsu_ready, e_space);
      chk($sformatf("rnd%0d_ardy", c),  bus.alu_ready, e_space && !bus.lsu_valid);
      chk($sformatf("rnd%0d_irdy", c),  bus.issue_ready, e_irdy);
      chk($sformatf("rnd%0d_busy1", c), bus.q_rs1_busy, (bus.q_rs1 != 0) && (pend[bus.q_rs1] != 0));
      chk($sformatf("rnd%0d_busy2", c), bus.q_rs2_busy, (bus.q_rs2 != 0) && (pend[bus.q_rs2] != 0));

      lsu_fire = bus.lsu_valid && e_space;
      alu_fire = bus.alu_valid && e_space && !bus.lsu_valid;
      if (e_wen) begin
        if (pend[mq[0].rd] > 0) pend[mq[0].rd]--;
        last_rd = mq[0].rd; last_data = mq[0].data;
        void'(mq.pop_front());
      end
      if (lsu_fire) begin
        if (bus.lsu_rd != 0) begin t.rd = bus.lsu_rd; t.data = bus.lsu_data; mq.push_back(t); end
        if (li >= 0) outst.delete(li);
      end else if (alu_fire) begin
        if (bus.alu_rd != 0) begin t.rd = bus.alu_rd; t.data = bus.alu_data; mq.push_back(t); end
        if (ai >= 0) outst.delete(ai);
      end
      if (bus.issue_valid && e_irdy && bus.issue_rd != 0) begin
        pend[bus.issue_rd]++;
        outst.push_back(bus.issue_rd);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
